// File: rtl/crossing_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : crossing_gate_controller
// Description : Per-crossing Moore FSMs driving warning lamps and gate motors
//               from voted train detection events, with fault trapping.
// Revision    : 1.0 - initial release
// ============================================================================
module crossing_gate_controller #(
    parameter int NUM_CROSSINGS = 4,
    parameter int WARN_CYCLES   = 16,
    parameter int WEATHER_EXTRA = 8,
    parameter int MOVE_TIMEOUT  = 32,
    parameter int CLEAR_HOLD    = 8,
    parameter int FLASH_DIV     = 4,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CROSSINGS-1:0] train_detected,
    input  logic [NUM_CROSSINGS-1:0] train_exited,
    input  logic [1:0]               weather_mode,
    input  logic [NUM_CROSSINGS-1:0] gate_down_sw,
    input  logic [NUM_CROSSINGS-1:0] gate_up_sw,
    input  logic                     fault_clear,
    output logic [NUM_CROSSINGS-1:0] lights_on,
    output logic [NUM_CROSSINGS-1:0] lamp_flash,
    output logic [NUM_CROSSINGS-1:0] gate_lower_cmd,
    output logic [NUM_CROSSINGS-1:0] gate_raise_cmd,
    output logic [NUM_CROSSINGS-1:0] crossing_closed,
    output logic [NUM_CROSSINGS-1:0] fault
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WARN       = 3'd1,
        ST_LOWERING   = 3'd2,
        ST_CLOSED     = 3'd3,
        ST_CLEAR_HOLD = 3'd4,
        ST_RAISING    = 3'd5,
        ST_FAULT      = 3'd6
    } state_t;

    localparam int               c_flash_w    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [c_flash_w-1:0] c_flash_wrap = c_flash_w'(FLASH_DIV - 1);
    localparam logic [c_flash_w-1:0] c_flash_one  = c_flash_w'(1);
    localparam logic [CNT_W-1:0] c_timer_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_move_load  = CNT_W'(MOVE_TIMEOUT);
    localparam logic [CNT_W-1:0] c_hold_load  = CNT_W'(CLEAR_HOLD);
    localparam logic [CNT_W-1:0] c_warn_load0 = CNT_W'(WARN_CYCLES);
    localparam logic [CNT_W-1:0] c_warn_load1 = CNT_W'(WARN_CYCLES + 1 * WEATHER_EXTRA);
    localparam logic [CNT_W-1:0] c_warn_load2 = CNT_W'(WARN_CYCLES + 2 * WEATHER_EXTRA);
    localparam logic [CNT_W-1:0] c_warn_load3 = CNT_W'(WARN_CYCLES + 3 * WEATHER_EXTRA);

    logic [c_flash_w-1:0] r_flash_cnt;
    logic                 r_flash_phase;
    logic [CNT_W-1:0]     w_warn_load;

    // Shared flash phase: all crossings blink in unison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= 1'b0;
        end else if (r_flash_cnt == c_flash_wrap) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= ~r_flash_phase;
        end else begin
            r_flash_cnt   <= r_flash_cnt + c_flash_one;
        end
    end

    always_comb begin
        w_warn_load = c_warn_load0;
        case (weather_mode)
            2'd1:    w_warn_load = c_warn_load1;
            2'd2:    w_warn_load = c_warn_load2;
            2'd3:    w_warn_load = c_warn_load3;
            default: w_warn_load = c_warn_load0;
        endcase
    end

    for (genvar g = 0; g < NUM_CROSSINGS; g++) begin : g_crossing
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_timer;
        logic [CNT_W-1:0] w_timer_nxt;
        logic             r_exit_pending;
        logic             w_exit_pending_nxt;
        logic             w_timer_done;

        // Timer holds the remaining cycles in the current timed state
        assign w_timer_done = (r_timer <= c_timer_one);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state        <= ST_IDLE;
                r_timer        <= '0;
                r_exit_pending <= 1'b0;
            end else begin
                r_state        <= w_state_nxt;
                r_timer        <= w_timer_nxt;
                r_exit_pending <= w_exit_pending_nxt;
            end
        end

        always_comb begin
            w_state_nxt        = r_state;
            w_timer_nxt        = r_timer;
            w_exit_pending_nxt = r_exit_pending;

            if ((r_state != ST_IDLE) && gate_down_sw[g] && gate_up_sw[g]) begin
                w_state_nxt = ST_FAULT;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (train_detected[g]) begin
                            w_state_nxt = ST_WARN;
                            w_timer_nxt = w_warn_load;
                        end
                    end
                    ST_WARN: begin
                        if (train_exited[g]) w_exit_pending_nxt = 1'b1;
                        if (w_timer_done) begin
                            w_state_nxt = ST_LOWERING;
                            w_timer_nxt = c_move_load;
                        end else begin
                            w_timer_nxt = r_timer - c_timer_one;
                        end
                    end
                    ST_LOWERING: begin
                        if (train_exited[g]) w_exit_pending_nxt = 1'b1;
                        if (gate_down_sw[g]) begin
                            w_state_nxt = ST_CLOSED;
                        end else if (w_timer_done) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_timer_nxt = r_timer - c_timer_one;
                        end
                    end
                    ST_CLOSED: begin
                        if (r_exit_pending || train_exited[g]) begin
                            w_state_nxt = ST_CLEAR_HOLD;
                            w_timer_nxt = c_hold_load;
                        end
                    end
                    ST_CLEAR_HOLD: begin
                        if (train_detected[g]) begin
                            w_state_nxt = ST_CLOSED;
                        end else if (w_timer_done) begin
                            w_state_nxt = ST_RAISING;
                            w_timer_nxt = c_move_load;
                        end else begin
                            w_timer_nxt = r_timer - c_timer_one;
                        end
                    end
                    ST_RAISING: begin
                        if (train_detected[g]) begin
                            w_state_nxt = ST_LOWERING;
                            w_timer_nxt = c_move_load;
                        end else if (gate_up_sw[g]) begin
                            w_state_nxt = ST_IDLE;
                        end else if (w_timer_done) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_timer_nxt = r_timer - c_timer_one;
                        end
                    end
                    ST_FAULT: begin
                        if (fault_clear && !train_detected[g]) w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            // A stale exit must never leak into the next train's cycle
            if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLEAR_HOLD) ||
                (w_state_nxt == ST_FAULT)) begin
                w_exit_pending_nxt = 1'b0;
            end
            if (w_state_nxt == ST_IDLE) w_timer_nxt = '0;
        end

        assign lights_on[g]       = (r_state != ST_IDLE);
        assign lamp_flash[g]      = (r_state != ST_IDLE) & r_flash_phase;
        assign gate_lower_cmd[g]  = (r_state == ST_LOWERING);
        assign gate_raise_cmd[g]  = (r_state == ST_RAISING);
        assign crossing_closed[g] = (r_state == ST_CLOSED) || (r_state == ST_CLEAR_HOLD);
        assign fault[g]           = (r_state == ST_FAULT);
    end

endmodule
`default_nettype wire
